ltc2324_capture: RTL and testbench
==================================

Name: ltc2324_capture

Overview:
- Front-end for the 4-channel, 16-bit serial ADC (LTC2324-16 style) that feeds the sample-to-DMA stage.
- Generates CNV and SCK in the adc_clk domain and deserialises SDO1..SDO4 MSB-first.
- Presents four parallel 16-bit words with a one-cycle valid strobe.
- Replaces the simulated data source in the sampler; runs free at a programmable conversion period while enabled.

Parameters:
- NBITS, 16, bits per channel per frame.
- SCK_DIV, 1, SCK half-period in adc_clk cycles (≥1).
- CNV_HIGH, 2, adc_CNV high time in adc_clk cycles (≥1).
- T_CONV, 45, adc_clk cycles from CNV falling to first SCK rising (≥1).

Ports:
- adc_clk  in  1  sole clock.
- adc_rst  in  1  reset. Asynchronous assertion, active-high. One clock domain throughout.
- enable  in  1  level; high = run conversions continuously.
- sample_period  in  16  adc_clk cycles between successive CNV rising edges.
- adc_CNV  out  1  conversion start to ADC.
- adc_SCK  out  1  serial clock to ADC.
- adc_SDO1..adc_SDO4  in  1 each  serial data lanes, channels 1..4.
- ch1_data..ch4_data  out  16 each  last completed sample per channel.
- data_valid  out  1  one-cycle pulse when chN_data update.
- busy  out  1  high from CNV rising until the DONE cycle inclusive.
- period_short  out  1  sticky: requested period below MIN_PERIOD.

Behaviour:
- MIN_PERIOD = CNV_HIGH + T_CONV + 2*SCK_DIV*NBITS + 1. Defaults give 80.
- Reset: all outputs are 0 (adc_CNV, adc_SCK, data, data_valid, busy, period_short). State is IDLE and counters are cleared. Assertion in any state aborts the frame immediately; no partial data is latched.
- FSM states: IDLE, CNV, WAIT, SHIFT, DONE.
- IDLE:
  - Entry from reset, or enable rising: go to CNV on the next cycle when enable=1.
  - Entry from DONE: go to CNV when period counter reaches eff_period-1.
  - eff_period = max(sample_period, MIN_PERIOD). sample_period=0 counts as short.
  - sample_period is latched on every CNV entry; changes take effect on the next frame.
- CNV: adc_CNV=1 for exactly CNV_HIGH cycles. Period counter resets to 0 on the first CNV cycle.
- WAIT: adc_CNV=0, SCK=0 for exactly T_CONV cycles.
- SHIFT:
  - adc_SCK toggles every SCK_DIV cycles, starting low-to-high. Exactly NBITS rising and NBITS falling edges. High and low phases are each SCK_DIV cycles.
  - On the adc_clk edge that drives SCK 1→0, shift each SDOn into its register (MSB first, left shift).
  - After the NBITS-th falling edge: go to DONE. SCK ends and idles low.
- DONE, one cycle:
  - ch1..ch4_data <= shift registers, data_valid=1.
  - Go to IDLE, or straight to CNV if the period has already elapsed, so back-to-back frames are allowed.
- Latency: data_valid asserts exactly CNV_HIGH+T_CONV+2*SCK_DIV*NBITS cycles after the first adc_CNV=1 cycle. Defaults: 79.
- period_short:
  - Set on any CNV entry where the latched sample_period < MIN_PERIOD.
  - Cleared only by reset or when enable=0 in IDLE.
- enable falling mid-frame (CNV/WAIT/SHIFT): the frame completes and delivers data_valid; no further CNV follows. No truncated frames ever.
- enable rising during DONE of the final frame: treated as still enabled; the normal period rule applies.
- chN_data hold their values between frames and across enable toggles. Only reset clears them.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset with enable=1, then hold adc_rst=1 for 5 cycles -> all outputs 0, no SCK or CNV toggling.
2. Defaults, enable=1, sample_period=200. SDO model shifts 0x8001, 0x1234, 0xFFFF, 0x0000 -> adc_CNV high for 2 cycles, first SCK rising 47 cycles after CNV rising, 16 SCK pulses (1 cycle high/1 low), data_valid at cycle 79 with exact words. Next CNV at cycle 200; period_short=0.
3. sample_period=50 -> CNV rising edges every 80 cycles, period_short=1 from the first frame. Then enable=0 -> period_short clears in IDLE.
4. enable deasserted during the 8th SCK pulse -> frame completes with correct data and a single data_valid; adc_CNV stays 0 afterwards.
5. adc_rst pulsed mid-SHIFT -> adc_SCK/adc_CNV low and data regs 0 the same cycle. After release, the first CNV occurs one cycle after enable is seen high; no stale data_valid.
6. SCK_DIV=3, T_CONV=10 -> SCK high 3 and low 3 cycles, data_valid at 2+10+96=108 cycles, MIN_PERIOD=109, data bit-exact.

Source files
------------

// File: rtl/ltc2324_capture.sv
// Capture front-end for a 4-lane, 16-bit serial ADC. It generates CNV and SCK,
// deserialises the four SDO lanes and presents one parallel word per channel.
module ltc2324_lane #(
  parameter int NBITS = 16
) (
  input  logic             adc_clk,
  input  logic             adc_rst,
  input  logic             shift_en,
  input  logic             load_en,
  input  logic             sdo,
  output logic [NBITS-1:0] data
);
  logic [NBITS-1:0] sr;

  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      sr   <= '0;
      data <= '0;
    end else begin
      if (shift_en) sr <= {sr[NBITS-2:0], sdo};
      if (load_en) data <= sr;
    end
  end
endmodule

module ltc2324_capture #(
  parameter int NBITS    = 16,
  parameter int SCK_DIV  = 1,
  parameter int CNV_HIGH = 2,
  parameter int T_CONV   = 45
) (
  input  logic             adc_clk,
  input  logic             adc_rst,
  input  logic             enable,
  input  logic [15:0]      sample_period,
  output logic             adc_CNV,
  output logic             adc_SCK,
  input  logic             adc_SDO1,
  input  logic             adc_SDO2,
  input  logic             adc_SDO3,
  input  logic             adc_SDO4,
  output logic [NBITS-1:0] ch1_data,
  output logic [NBITS-1:0] ch2_data,
  output logic [NBITS-1:0] ch3_data,
  output logic [NBITS-1:0] ch4_data,
  output logic             data_valid,
  output logic             busy,
  output logic             period_short
);
  localparam int NUM_LANES = 4;
  localparam int BW = $clog2(NBITS + 1);
  localparam int MIN_PERIOD = CNV_HIGH + T_CONV + 2 * SCK_DIV * NBITS + 1;
  localparam logic [15:0] MIN_P = 16'(MIN_PERIOD);

  typedef enum logic [2:0] {IDLE, CNV, WAIT, SHIFT, DONE} state_t;

  state_t          st;
  logic [15:0]     cnt;
  logic [15:0]     pcnt;
  logic [15:0]     per_lat;
  logic [BW-1:0]   bits;
  logic            pending;
  logic [15:0]     eff_period;
  logic            period_due;
  logic            sck_edge;
  logic            shift_en;
  logic            load_en;
  logic            start;

  logic [NUM_LANES-1:0]            sdo_lanes;
  logic [NUM_LANES-1:0][NBITS-1:0] lane_data;

  assign eff_period = (per_lat < MIN_P) ? MIN_P : per_lat;
  assign period_due = (pcnt >= eff_period - 16'd1);
  assign sck_edge   = (cnt == 16'(SCK_DIV - 1));
  assign shift_en   = (st == SHIFT) && sck_edge && adc_SCK;
  assign load_en    = (st == SHIFT) && sck_edge && !adc_SCK && (bits == BW'(NBITS));

  // pending marks "a frame has run since enable came up": the period rule then
  // gates the next CNV, otherwise a fresh enable starts one immediately.
  assign start = enable && (((st == IDLE) && (!pending || period_due)) ||
                            ((st == DONE) && period_due));

  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      st           <= IDLE;
      cnt          <= '0;
      pcnt         <= '0;
      per_lat      <= '0;
      bits         <= '0;
      pending      <= 1'b0;
      adc_CNV      <= 1'b0;
      adc_SCK      <= 1'b0;
      data_valid   <= 1'b0;
      busy         <= 1'b0;
      period_short <= 1'b0;
    end else begin
      data_valid <= load_en;
      if (pcnt != 16'hFFFF) pcnt <= pcnt + 16'd1;
      if (start) begin
        st      <= CNV;
        adc_CNV <= 1'b1;
        cnt     <= '0;
        pcnt    <= '0;
        per_lat <= sample_period;
        busy    <= 1'b1;
        pending <= 1'b1;
        if (sample_period < MIN_P) period_short <= 1'b1;
      end else begin
        case (st)
          IDLE: begin
            if (!enable) begin
              pending      <= 1'b0;
              period_short <= 1'b0;
            end
          end
          CNV: begin
            if (cnt == 16'(CNV_HIGH - 1)) begin
              st      <= WAIT;
              adc_CNV <= 1'b0;
              cnt     <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          WAIT: begin
            if (cnt == 16'(T_CONV - 1)) begin
              st      <= SHIFT;
              adc_SCK <= 1'b1;
              cnt     <= '0;
              bits    <= '0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          SHIFT: begin
            // Lanes sample on the same edge that drops SCK; the last low phase
            // runs its full length before DONE.
            if (sck_edge) begin
              cnt <= '0;
              if (adc_SCK) begin
                adc_SCK <= 1'b0;
                bits    <= bits + BW'(1);
              end else if (bits == BW'(NBITS)) begin
                st <= DONE;
              end else begin
                adc_SCK <= 1'b1;
              end
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          DONE: begin
            st   <= IDLE;
            busy <= 1'b0;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

  assign sdo_lanes = {adc_SDO4, adc_SDO3, adc_SDO2, adc_SDO1};

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    ltc2324_lane #(.NBITS(NBITS)) u_lane (
      .adc_clk  (adc_clk),
      .adc_rst  (adc_rst),
      .shift_en (shift_en),
      .load_en  (load_en),
      .sdo      (sdo_lanes[gi]),
      .data     (lane_data[gi])
    );
  end

  assign ch1_data = lane_data[0];
  assign ch2_data = lane_data[1];
  assign ch3_data = lane_data[2];
  assign ch4_data = lane_data[3];
endmodule

// File: tb/tb_ltc2324_capture.sv
// Directed bench: a default-parameter instance and a SCK_DIV=3/T_CONV=10 instance,
// each fed by an ADC model that shifts a known word per lane MSB first.
module tb_ltc2324_capture;
  logic adc_clk = 1'b0;
  logic adc_rst = 1'b1;
  logic [1:0] en = 2'b01;
  logic [15:0] sp [2];
  logic [1:0] cnv, sck, dv, busy, ps;
  logic [1:0][3:0] sdo;
  logic [1:0][3:0][15:0] dat;
  logic [1:0][3:0][15:0] wd;

  int cyc = 0, n_chk = 0, n_err = 0;
  int n_cnv[2] = '{0, 0}, n_dv[2] = '{0, 0}, n_sck[2] = '{0, 0};
  int scnt[2] = '{0, 0}, idx[2] = '{0, 0}, run[2] = '{0, 0}, cnv_run[2] = '{0, 0};
  int hi_min[2] = '{999, 999}, hi_max[2] = '{0, 0};
  int lo_min[2] = '{999, 999}, lo_max[2] = '{0, 0};
  int t_cnv[2][64], t_dv[2][64], t_sck1[2][64], sck_fr[2][64], cnv_len[2][64];
  logic ps_dv[2][64];
  logic [1:0] cnv_q = 2'b00, sck_q = 2'b00;
  int mf;
  int r, c0, x, y, z, v;

  always #5 adc_clk = ~adc_clk;
  always @(posedge adc_clk) cyc <= cyc + 1;

  ltc2324_capture u_dut (
    .adc_clk(adc_clk), .adc_rst(adc_rst), .enable(en[0]), .sample_period(sp[0]),
    .adc_CNV(cnv[0]), .adc_SCK(sck[0]),
    .adc_SDO1(sdo[0][3]), .adc_SDO2(sdo[0][2]), .adc_SDO3(sdo[0][1]), .adc_SDO4(sdo[0][0]),
    .ch1_data(dat[0][3]), .ch2_data(dat[0][2]), .ch3_data(dat[0][1]), .ch4_data(dat[0][0]),
    .data_valid(dv[0]), .busy(busy[0]), .period_short(ps[0]));

  ltc2324_capture #(.SCK_DIV(3), .T_CONV(10)) u_dut2 (
    .adc_clk(adc_clk), .adc_rst(adc_rst), .enable(en[1]), .sample_period(sp[1]),
    .adc_CNV(cnv[1]), .adc_SCK(sck[1]),
    .adc_SDO1(sdo[1][3]), .adc_SDO2(sdo[1][2]), .adc_SDO3(sdo[1][1]), .adc_SDO4(sdo[1][0]),
    .ch1_data(dat[1][3]), .ch2_data(dat[1][2]), .ch3_data(dat[1][1]), .ch4_data(dat[1][0]),
    .data_valid(dv[1]), .busy(busy[1]), .period_short(ps[1]));

  // ADC model plus event recorder, evaluated away from the active edge.
  always @(negedge adc_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cnv[i]) idx[i] = 0;
      else if (sck_q[i] && !sck[i] && idx[i] < 16) idx[i]++;
      for (int c = 0; c < 4; c++) sdo[i][c] = (idx[i] < 16) ? wd[i][c][15 - idx[i]] : 1'b0;
      if (cnv[i] && !cnv_q[i]) begin
        if (n_cnv[i] < 64) t_cnv[i][n_cnv[i]] = cyc;
        n_cnv[i]++;
        cnv_run[i] = 0;
        scnt[i] = 0;
      end
      if (cnv[i]) cnv_run[i]++;
      mf = (n_cnv[i] > 0) ? ((n_cnv[i] > 64) ? 63 : n_cnv[i] - 1) : 0;
      if (!cnv[i] && cnv_q[i]) cnv_len[i][mf] = cnv_run[i];
      if (sck[i] != sck_q[i]) begin
        if (sck[i]) begin
          n_sck[i]++;
          if (scnt[i] == 0) t_sck1[i][mf] = cyc;
          else begin
            if (run[i] < lo_min[i]) lo_min[i] = run[i];
            if (run[i] > lo_max[i]) lo_max[i] = run[i];
          end
          scnt[i]++;
          sck_fr[i][mf] = scnt[i];
        end else begin
          if (run[i] < hi_min[i]) hi_min[i] = run[i];
          if (run[i] > hi_max[i]) hi_max[i] = run[i];
        end
        run[i] = 1;
      end else begin
        run[i]++;
      end
      if (dv[i]) begin
        if (n_dv[i] < 64) begin
          t_dv[i][n_dv[i]] = cyc;
          ps_dv[i][n_dv[i]] = ps[i];
        end
        n_dv[i]++;
      end
      cnv_q[i] = cnv[i];
      sck_q[i] = sck[i];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge adc_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    sp[0] = 16'd200;
    sp[1] = 16'd0;
    wd[0] = 64'h8001_1234_FFFF_0000;
    wd[1] = 64'hC003_3CC3_8000_0001;

    // 1: reset held with enable high
    repeat (5) @(negedge adc_clk);
    chk("rst_cnv", 64'(cnv), 64'h0);
    chk("rst_sck", 64'(sck), 64'h0);
    chk("rst_dv", 64'(dv), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_ps", 64'(ps), 64'h0);
    chk("rst_data0", dat[0], 64'h0);
    chk("rst_data1", dat[1], 64'h0);
    chk("rst_toggles", 64'(n_cnv[0] + n_sck[0] + n_cnv[1] + n_sck[1]), 64'h0);
    r = cyc;
    adc_rst = 1'b0;
    c0 = r + 1;

    // 2: default timing, period 200
    wait_cyc(c0 + 100);
    chk("first_cnv", 64'(t_cnv[0][0]), 64'(c0));
    chk("cnv_len", 64'(cnv_len[0][0]), 64'd2);
    chk("sck1_lat", 64'(t_sck1[0][0] - t_cnv[0][0]), 64'd47);
    chk("sck_pulses", 64'(sck_fr[0][0]), 64'd16);
    chk("sck_hilo", {16'(hi_min[0]), 16'(hi_max[0]), 16'(lo_min[0]), 16'(lo_max[0])},
        64'h0001_0001_0001_0001);
    chk("dv_lat", 64'(t_dv[0][0] - t_cnv[0][0]), 64'd79);
    chk("data_f0", dat[0], 64'h8001_1234_FFFF_0000);
    chk("busy_idle", 64'(busy[0]), 64'h0);
    chk("dv_count_f0", 64'(n_dv[0]), 64'd1);
    wd[0] = 64'hA5A5_5A5A_0F0F_7FFE;
    wait_cyc(c0 + 285);
    chk("period_200", 64'(t_cnv[0][1] - t_cnv[0][0]), 64'd200);
    chk("dv_lat_f1", 64'(t_dv[0][1] - t_cnv[0][1]), 64'd79);
    chk("data_f1", dat[0], 64'hA5A5_5A5A_0F0F_7FFE);
    chk("ps_long", 64'(ps[0]), 64'h0);
    en[0] = 1'b0;
    wait_cyc(c0 + 435);
    chk("no_cnv_disabled", 64'(n_cnv[0]), 64'd2);

    // 3: short period clamps to 80 and flags period_short
    sp[0] = 16'd50;
    x = cyc;
    en[0] = 1'b1;
    wait_cyc(x + 251);
    en[0] = 1'b0;
    chk("short_start", 64'(t_cnv[0][2] - x), 64'd1);
    chk("short_per_a", 64'(t_cnv[0][3] - t_cnv[0][2]), 64'd80);
    chk("short_per_b", 64'(t_cnv[0][4] - t_cnv[0][3]), 64'd80);
    chk("ps_first_frame", 64'(ps_dv[0][2]), 64'h1);
    chk("ps_sticky", 64'(ps[0]), 64'h1);
    wait_cyc(x + 330);
    chk("ps_cleared", 64'(ps[0]), 64'h0);
    chk("short_cnv_cnt", 64'(n_cnv[0]), 64'd6);
    chk("short_dv_cnt", 64'(n_dv[0]), 64'd6);
    chk("data_short", dat[0], 64'hA5A5_5A5A_0F0F_7FFE);

    // 4: enable drops during the 8th SCK pulse
    sp[0] = 16'd200;
    wd[0] = 64'h0123_4567_89AB_CDEF;
    y = cyc;
    en[0] = 1'b1;
    wait_cyc(y + 62);
    chk("sck8_high", 64'(sck[0]), 64'h1);
    en[0] = 1'b0;
    wait_cyc(y + 200);
    chk("drop_cnv_cnt", 64'(n_cnv[0]), 64'd7);
    chk("drop_dv_cnt", 64'(n_dv[0]), 64'd7);
    chk("drop_data", dat[0], 64'h0123_4567_89AB_CDEF);
    chk("drop_dv_lat", 64'(t_dv[0][6] - t_cnv[0][6]), 64'd79);
    chk("drop_cnv_low", 64'(cnv[0]), 64'h0);

    // 5: reset pulse mid-SHIFT
    wd[0] = 64'hFEDC_BA98_7654_3210;
    z = cyc;
    en[0] = 1'b1;
    wait_cyc(z + 61);
    @(posedge adc_clk);
    #1;
    chk("pre_rst_sck", 64'(sck[0]), 64'h1);
    #1 adc_rst = 1'b1;
    #1;
    chk("rst_mid_sck", 64'(sck[0]), 64'h0);
    chk("rst_mid_cnv", 64'(cnv[0]), 64'h0);
    chk("rst_mid_data", dat[0], 64'h0);
    chk("rst_mid_busy", 64'(busy[0]), 64'h0);
    repeat (3) @(negedge adc_clk);
    r = cyc;
    adc_rst = 1'b0;
    wait_cyc(r + 71);
    chk("no_stale_dv", 64'(n_dv[0]), 64'd7);
    chk("cnv_after_rst", 64'(t_cnv[0][8]), 64'(r + 1));
    wait_cyc(r + 86);
    chk("rst_dv_cnt", 64'(n_dv[0]), 64'd8);
    chk("rst_data_new", dat[0], 64'hFEDC_BA98_7654_3210);
    en[0] = 1'b0;

    // 6: SCK_DIV=3, T_CONV=10 instance, sample_period=0 -> 109
    v = cyc;
    en[1] = 1'b1;
    wait_cyc(v + 125);
    en[1] = 1'b0;
    chk("d2_first_cnv", 64'(t_cnv[1][0]), 64'(v + 1));
    chk("d2_cnv_len", 64'(cnv_len[1][0]), 64'd2);
    chk("d2_sck1_lat", 64'(t_sck1[1][0] - t_cnv[1][0]), 64'd12);
    chk("d2_pulses", 64'(sck_fr[1][0]), 64'd16);
    chk("d2_sck_hilo", {16'(hi_min[1]), 16'(hi_max[1]), 16'(lo_min[1]), 16'(lo_max[1])},
        64'h0003_0003_0003_0003);
    chk("d2_dv_lat", 64'(t_dv[1][0] - t_cnv[1][0]), 64'd108);
    chk("d2_data", dat[1], 64'hC003_3CC3_8000_0001);
    chk("d2_period", 64'(t_cnv[1][1] - t_cnv[1][0]), 64'd109);
    chk("d2_ps", 64'(ps[1]), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
